// File: rtl/lock_pkg.sv
// Shared types and helpers for the serial code lock: FSM state encoding,
// MSB-first symbol extraction from a packed code, and a ceiling-log2.
package lock_pkg;

    typedef enum logic [1:0] {
        ENTRY    = 2'd0,
        UNLOCKED = 2'd1,
        LOCKOUT  = 2'd2
    } lock_state_t;

    // Upper bounds for the generic symbol selector; callers zero-extend into these.
    localparam int MAX_CODE_BITS = 256;
    localparam int MAX_SYM_BITS  = 32;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic logic [MAX_SYM_BITS-1:0] sym_sel(
        input logic [MAX_CODE_BITS-1:0] code,
        input int                       idx,
        input int                       sym_w,
        input int                       code_len
    );
        logic [MAX_CODE_BITS-1:0] shifted;
        logic [MAX_SYM_BITS-1:0]  sym;
        shifted = code >> ((code_len - 1 - idx) * sym_w);
        sym     = '0;
        for (int b = 0; b < MAX_SYM_BITS; b++) begin
            if (b < sym_w) begin
                sym[b] = shifted[b];
            end else begin
                sym[b] = 1'b0;
            end
        end
        return sym;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the unlock window and the lockout period.
module lock_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load has priority; decrement saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/serial_code_lock.sv
// Serial keyed code lock: sticky-mismatch symbol comparator, failed-attempt
// counting with timed lockout, timed unlock window and code reprogramming.
module serial_code_lock
    import lock_pkg::*;
#(
    parameter int                               CODE_LEN       = 4,
    parameter int                               SYMBOL_W       = 4,
    parameter logic [CODE_LEN*SYMBOL_W-1:0]     DEFAULT_CODE   = 16'h1234,
    parameter int                               MAX_TRIES      = 3,
    parameter int                               LOCKOUT_CYCLES = 1000,
    parameter int                               UNLOCK_CYCLES  = 500
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                key_valid,
    input  logic [SYMBOL_W-1:0]                 key_sym,
    input  logic                                abort,
    input  logic                                code_wr,
    input  logic [CODE_LEN*SYMBOL_W-1:0]        code_in,
    output logic                                unlocked,
    output logic                                lockout,
    output logic                                match_pulse,
    output logic                                fail_pulse,
    output logic [clog2(CODE_LEN+1)-1:0]        sym_count,
    output logic [clog2(MAX_TRIES+1)-1:0]       fail_count
);

    localparam int CODE_W = CODE_LEN * SYMBOL_W;
    localparam int SCW    = clog2(CODE_LEN + 1);
    localparam int FCW    = clog2(MAX_TRIES + 1);
    localparam int TMAX   = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
    localparam int TW     = (clog2(TMAX) < 1) ? 1 : clog2(TMAX);

    localparam logic [SCW-1:0] LAST_SYM   = SCW'(CODE_LEN - 1);
    localparam logic [FCW-1:0] TRIES_MAX  = FCW'(MAX_TRIES);
    localparam logic [TW-1:0]  UNLOCK_LD  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0]  LOCKOUT_LD = TW'(LOCKOUT_CYCLES - 1);

    lock_state_t         state_q, state_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [SCW-1:0]      sym_count_q, sym_count_d;
    logic [FCW-1:0]      fail_count_q, fail_count_d;
    logic                mis_q, mis_d;
    logic                match_q, match_d;
    logic                fail_q, fail_d;
    logic                unlocked_q, lockout_q;

    logic                          tmr_load;
    logic [TW-1:0]                 tmr_value;
    logic                          tmr_en;
    logic                          tmr_zero;
    logic [MAX_SYM_BITS-1:0]       exp_sym;
    logic                          sym_neq;

    lock_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .value (tmr_value),
        .en    (tmr_en),
        .zero  (tmr_zero)
    );

    assign exp_sym = sym_sel(MAX_CODE_BITS'(code_q), int'(sym_count_q), SYMBOL_W, CODE_LEN);
    assign sym_neq = (exp_sym != MAX_SYM_BITS'(key_sym));

    // Next-state, comparator bookkeeping and timer control.
    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        sym_count_d  = sym_count_q;
        fail_count_d = fail_count_q;
        mis_d        = mis_q;
        match_d      = 1'b0;
        fail_d       = 1'b0;
        tmr_load     = 1'b0;
        tmr_value    = '0;
        tmr_en       = 1'b0;
        case (state_q)
            ENTRY: begin
                if (abort) begin
                    sym_count_d = '0;
                    mis_d       = 1'b0;
                end else if (key_valid && (sym_count_q == LAST_SYM)) begin
                    sym_count_d = '0;
                    mis_d       = 1'b0;
                    if (!mis_q && !sym_neq) begin
                        match_d      = 1'b1;
                        fail_count_d = '0;
                        state_d      = UNLOCKED;
                        tmr_load     = 1'b1;
                        tmr_value    = UNLOCK_LD;
                    end else if ((fail_count_q + FCW'(1)) == TRIES_MAX) begin
                        fail_d       = 1'b1;
                        fail_count_d = '0;
                        state_d      = LOCKOUT;
                        tmr_load     = 1'b1;
                        tmr_value    = LOCKOUT_LD;
                    end else begin
                        fail_d       = 1'b1;
                        fail_count_d = fail_count_q + FCW'(1);
                    end
                end else if (key_valid) begin
                    sym_count_d = sym_count_q + SCW'(1);
                    mis_d       = mis_q | sym_neq;
                end else begin
                    sym_count_d = sym_count_q;
                end
            end
            UNLOCKED: begin
                // A write always extends the window, even on the expiry edge.
                if (code_wr) begin
                    code_d    = code_in;
                    tmr_load  = 1'b1;
                    tmr_value = UNLOCK_LD;
                end else if (tmr_zero) begin
                    state_d = ENTRY;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            LOCKOUT: begin
                if (tmr_zero) begin
                    state_d     = ENTRY;
                    sym_count_d = '0;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: begin
                state_d     = ENTRY;
                sym_count_d = '0;
                mis_d       = 1'b0;
            end
        endcase
    end

    // State, code, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ENTRY;
            code_q       <= DEFAULT_CODE;
            sym_count_q  <= '0;
            fail_count_q <= '0;
            mis_q        <= 1'b0;
            match_q      <= 1'b0;
            fail_q       <= 1'b0;
            unlocked_q   <= 1'b0;
            lockout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            sym_count_q  <= sym_count_d;
            fail_count_q <= fail_count_d;
            mis_q        <= mis_d;
            match_q      <= match_d;
            fail_q       <= fail_d;
            unlocked_q   <= (state_d == UNLOCKED);
            lockout_q    <= (state_d == LOCKOUT);
        end
    end

    assign unlocked    = unlocked_q;
    assign lockout     = lockout_q;
    assign match_pulse = match_q;
    assign fail_pulse  = fail_q;
    assign sym_count   = sym_count_q;
    assign fail_count  = fail_count_q;

endmodule
